// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B, one bit per clock, LSB first, start/busy/done handshake.
// Optional signed-overflow output V is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb, res, res_n;
  logic [CW-1:0]    cnt;
  logic             br, br_n, diff, bit_a, bit_b;
  logic             accept, last;
`ifdef SUB_OVERFLOW_EN
  logic             am, bm;
`endif

  // one full-subtractor step per RUN cycle; accept also fires in DONE for back-to-back ops
  always_comb begin
    state_n = state;
    bit_a   = sa[0];
    bit_b   = sb[0];
    diff    = bit_a ^ bit_b ^ br;
    br_n    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
    res_n   = {diff, res[WIDTH-1:1]};
    accept  = start && (state != RUN);
    last    = (state == RUN) && (cnt == CW'(WIDTH - 1));
    unique case (state)
      IDLE:    state_n = accept ? RUN : IDLE;
      RUN:     state_n = last ? DONE : RUN;
      DONE:    state_n = accept ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      am    <= 1'b0;
      bm    <= 1'b0;
      V     <= 1'b0;
`endif
    end else begin
      state <= state_n;
      done  <= 1'b0;
      if (accept) begin
        sa   <= A;
        sb   <= B;
        res  <= '0;
        cnt  <= '0;
        br   <= 1'b0;
        busy <= 1'b1;
`ifdef SUB_OVERFLOW_EN
        am   <= A[WIDTH-1];
        bm   <= B[WIDTH-1];
`endif
      end else if (state == RUN) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        res <= res_n;
        br  <= br_n;
        cnt <= cnt + CW'(1);
        // outputs only move on the completion edge, never showing partial bits
        if (last) begin
          D    <= res_n;
          Bout <= br_n;
          done <= 1'b1;
          busy <= 1'b0;
`ifdef SUB_OVERFLOW_EN
          V    <= (am != bm) && (res_n[WIDTH-1] != am);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): vector table, handshake corner cases,
// random and exhaustive operand pairs against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [WIDTH-1:0] D;
  logic             Bout, busy, done;
`ifdef SUB_OVERFLOW_EN
  logic             V;
`endif

  int testCount = 0;
  int failCount = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .D(D), .Bout(Bout), .busy(busy), .done(done)
`ifdef SUB_OVERFLOW_EN
    , .V(V)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int expD;
    int expBout;
    int expV;
  } vec_t;

  task automatic checkOutput(input string name, input int got, input int exp);
    testCount++;
    if (got != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Issue one op from a negedge; returns sampled results at the done pulse and edges taken.
  task automatic applyStimulus(input int a, input int b, output int gotD, output int gotBout,
                               output int gotV, output int gotBusy, output int lat);
    A = WIDTH'(a);
    B = WIDTH'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = WIDTH'($urandom);
    B = WIDTH'($urandom);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    gotD = int'(D);
    gotBout = int'(Bout);
    gotBusy = int'(busy);
`ifdef SUB_OVERFLOW_EN
    gotV = int'(V);
`else
    gotV = 0;
`endif
  endtask

  function automatic void refModel(input int a, input int b, output int rd, output int rb,
                                   output int rv);
    int sa, sb, sd;
    rd = (a - b + 16) % 16;
    rb = (a < b) ? 1 : 0;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    sd = sa - sb;
    rv = (sd > 7 || sd < -8) ? 1 : 0;
  endfunction

  task automatic doOp(input string name, input int a, input int b, input int expD,
                      input int expBout, input int expV);
    int gd, gb, gv, gbusy, lat;
    applyStimulus(a, b, gd, gb, gv, gbusy, lat);
    checkOutput({name, " latency"}, lat, WIDTH + 1);
    checkOutput({name, " D"}, gd, expD);
    checkOutput({name, " Bout"}, gb, expBout);
    checkOutput({name, " busy at done"}, gbusy, 0);
`ifdef SUB_OVERFLOW_EN
    checkOutput({name, " V"}, gv, expV);
`endif
    @(negedge clk);
    checkOutput({name, " done one cycle"}, int'(done), 0);
  endtask

  initial begin
    vec_t vecs[$];
    int gd, gb, gv, gbusy, lat, rd, rb, rv, ra, rbb;
    bit sawDone;

    vecs.push_back('{15, 1, 14, 0, 0});
    vecs.push_back('{1, 15, 2, 1, 0});
    vecs.push_back('{0, 1, 15, 1, 0});
    vecs.push_back('{5, 5, 0, 0, 0});
    vecs.push_back('{8, 1, 7, 0, 1});
    vecs.push_back('{7, 1, 6, 0, 0});
    vecs.push_back('{0, 8, 8, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 0});

    repeat (2) @(negedge clk);
    checkOutput("reset D", int'(D), 0);
    checkOutput("reset Bout", int'(Bout), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      doOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].expD, vecs[i].expBout,
           vecs[i].expV);

    // previous result holds until the next done pulse
    doOp("hold setup", 15, 1, 14, 0, 0);
    A = 4'd5; B = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold D run1", int'(D), 14);
    checkOutput("busy run1", int'(busy), 1);
    @(negedge clk);
    checkOutput("hold D run2", int'(D), 14);
    lat = 2;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    checkOutput("hold latency", lat, WIDTH + 1);
    checkOutput("hold new D", int'(D), 0);
    @(negedge clk);

    // start while busy ignored; start during done begins a back-to-back op
    A = 4'd9; B = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd0; B = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    checkOutput("busy-start latency", lat, WIDTH + 1);
    checkOutput("busy-start D", int'(D), 6);
    checkOutput("busy-start Bout", int'(Bout), 0);
    A = 4'd12; B = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b done drops", int'(done), 0);
    checkOutput("b2b busy rises", int'(busy), 1);
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    checkOutput("b2b latency", lat, WIDTH + 1);
    checkOutput("b2b D", int'(D), 7);
    checkOutput("b2b Bout", int'(Bout), 0);
    @(negedge clk);

    // reset in the middle of RUN aborts without a done pulse
    doOp("pre-abort", 0, 1, 15, 1, 0);
    A = 4'd3; B = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort D", int'(D), 0);
    checkOutput("abort Bout", int'(Bout), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort no done", int'(sawDone), 0);
    doOp("post-abort", 10, 3, 7, 0, 0);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom_range(0, 15);
      rbb = $urandom_range(0, 15);
      refModel(ra, rbb, rd, rb, rv);
      doOp($sformatf("rand %0d-%0d", ra, rbb), ra, rbb, rd, rb, rv);
    end

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        refModel(a, b, rd, rb, rv);
        doOp($sformatf("sweep %0d-%0d", a, b), a, b, rd, rb, rv);
      end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
